// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller.
// Qualifies a start bit at its half-bit point, then times each data, parity and stop bit.
// It drives start/btu/done strobes into the receive datapath.
module uart_rx_ctrl #(
   parameter int unsigned CNT_W = 19
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_rx,
   input  logic [CNT_W-1:0] i_baud_k,
   input  logic             i_eight,
   input  logic             i_pen,
   output logic             o_start,
   output logic             o_btu,
   output logic             o_done,
   output logic             o_busy
);

   typedef enum logic [1:0] {StIdle, StStartChk, StReceive} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] k_q, k_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       n_q, n_d;
   logic             btu_q, btu_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] half_last;
   logic [CNT_W-1:0] bit_last;

   // Terminal counts derive from the k latched at start-bit detection, never the live input.
   assign half_last = (k_q >> 1) - CNT_W'(1);
   assign bit_last  = k_q - CNT_W'(1);

   // State, counters, latched configuration and registered strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         k_q       <= '0;
         bit_cnt_q <= '0;
         n_q       <= '0;
         btu_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         bit_cnt_q <= bit_cnt_d;
         n_q       <= n_d;
         btu_q     <= btu_d;
         done_q    <= done_d;
      end
   end

   // Next-state, counter sequencing and look-ahead decode of the btu/done strobes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      bit_cnt_d = bit_cnt_q;
      n_d       = n_q;
      btu_d     = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (!i_rx) begin
               state_d = StStartChk;
               k_d     = (i_baud_k < CNT_W'(2)) ? CNT_W'(2) : i_baud_k;
               n_d     = 4'd8 + {3'b000, i_eight} + {3'b000, i_pen};
            end
         end
         StStartChk: begin
            if (cnt_q == half_last) begin
               cnt_d = '0;
               if (!i_rx) begin
                  state_d   = StReceive;
                  bit_cnt_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StReceive: begin
            if (cnt_q == bit_last) begin
               cnt_d     = '0;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_d == n_q) begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Strobes are registered: assert them one cycle ahead of the counter reaching terminal.
      // k_q >= 2 whenever RECEIVE is entered, so a freshly cleared counter never matches.
      btu_d  = (state_d == StReceive) && (cnt_d == bit_last);
      done_d = btu_d && (bit_cnt_d == (n_q - 4'd1));
   end

   assign o_start = (state_q == StStartChk);
   assign o_busy  = (state_q != StIdle);
   assign o_btu   = btu_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: scoreboard queues filled by stimulus, drained by monitor.
module tb_uart_rx_ctrl;

   localparam int unsigned CNT_W = 19;

   typedef struct {
      int cyc;
      bit done;
   } btu_exp_t;

   typedef struct {
      int cyc;
      int len;
   } start_exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             rx = 1'b1;
   logic [CNT_W-1:0] baud_k = 19'd16;
   logic             eight = 1'b1;
   logic             pen = 1'b1;
   logic             start, btu, done, busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   btu_exp_t   btu_q[$];
   start_exp_t start_q[$];
   int         busy_q[$];

   uart_rx_ctrl #(.CNT_W(CNT_W)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_rx     (rx),
      .i_baud_k (baud_k),
      .i_eight  (eight),
      .i_pen    (pen),
      .o_start  (start),
      .o_btu    (btu),
      .o_done   (done),
      .o_busy   (busy)
   );

   always #5 clk = ~clk;

   // Cycle index n names the cycle whose state follows the n-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Serial level of bit idx in a frame: start, data LSB first, optional even parity, stop.
   function automatic logic frame_bit(input int idx, input logic [7:0] data, input bit e8,
                                      input bit p);
      int nd;
      logic [7:0] d;
      nd = e8 ? 8 : 7;
      d  = e8 ? data : {1'b0, data[6:0]};
      if (idx == 0) return 1'b0;
      if (idx <= nd) return d[idx-1];
      if (p && idx == nd + 1) return ^d;
      return 1'b1;
   endfunction

   // Monitor: pops expectations whenever the DUT presents a strobe or ends a level.
   bit prev_start = 1'b0;
   bit prev_busy  = 1'b0;
   int start_rise = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_start = 1'b0;
         prev_busy  = 1'b0;
      end else begin
         if (btu || done) begin
            if (btu_q.size() == 0) begin
               check("btu_unexpected", 1, 0);
            end else begin
               btu_exp_t e;
               e = btu_q.pop_front();
               check("btu_cycle", cyc, e.cyc);
               check("btu_level", int'(btu), 1);
               check("done_flag", int'(done), int'(e.done));
            end
         end
         if (start && !prev_start) start_rise = cyc;
         if (!start && prev_start) begin
            if (start_q.size() == 0) begin
               check("start_unexpected", 1, 0);
            end else begin
               start_exp_t s;
               s = start_q.pop_front();
               check("start_begin", start_rise, s.cyc);
               check("start_len", cyc - start_rise, s.len);
            end
         end
         if (!busy && prev_busy) begin
            if (busy_q.size() == 0) check("busy_unexpected", 1, 0);
            else check("busy_end", cyc, busy_q.pop_front());
         end
         prev_start = start;
         prev_busy  = busy;
      end
   end

   task automatic reset_check(input string tag);
      check({tag, "_start"}, int'(start), 0);
      check({tag, "_btu"}, int'(btu), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   // Drives one frame from the next falling edge and queues what the DUT must produce.
   // chg_btu>0: swap config after that btu. abort_btu>0: async reset after that btu.
   task automatic send_frame(input int k_in, input bit e8, input bit p, input logic [7:0] data,
                             input int chg_btu, input int new_k, input bit new_p,
                             input int abort_btu);
      int k, h, n, c0, end_cyc, chg_cyc, abort_cyc;
      bit stop;
      @(negedge clk);
      baud_k = CNT_W'(k_in);
      eight  = e8;
      pen    = p;
      rx     = 1'b0;
      k  = (k_in < 2) ? 2 : k_in;
      h  = k / 2;
      n  = 8 + int'(e8) + int'(p);
      c0 = cyc + 1;
      start_q.push_back('{cyc: c0, len: h});
      for (int j = 1; j <= n; j++) btu_q.push_back('{cyc: c0 + h - 1 + j * k, done: (j == n)});
      busy_q.push_back(c0 + h + n * k);
      end_cyc   = c0 + h - 1 + n * k;
      chg_cyc   = c0 + h - 1 + chg_btu * k + 1;
      abort_cyc = c0 + h - 1 + abort_btu * k + 2;
      stop = 1'b0;
      while (cyc < end_cyc && !stop) begin
         @(negedge clk);
         rx = frame_bit((cyc - (c0 - 1)) / k, data, e8, p);
         if (chg_btu > 0 && cyc == chg_cyc) begin
            baud_k = CNT_W'(new_k);
            pen    = new_p;
         end
         if (abort_btu > 0 && cyc == abort_cyc) begin
            #2 rst_n = 1'b0;
            btu_q.delete();
            start_q.delete();
            busy_q.delete();
            #1 reset_check("abort");
            rx = 1'b1;
            @(negedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
            stop = 1'b1;
         end
      end
   endtask

   task automatic idle(input int cycles);
      rx = 1'b1;
      repeat (cycles) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 reset_check("reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(4);
      reset_check("idle");

      // Nominal 8 data + parity, k=16: btu at 23..167 relative to START_CHK entry.
      send_frame(16, 1'b1, 1'b1, 8'h6C, 0, 0, 1'b0, 0);
      idle(5);

      // Frame-length variants.
      send_frame(16, 1'b0, 1'b0, 8'h55, 0, 0, 1'b0, 0);
      idle(3);
      send_frame(16, 1'b1, 1'b0, 8'hA3, 0, 0, 1'b0, 0);
      idle(3);

      // Glitch: 3 low cycles then high; START_CHK for 8 cycles, no strobes.
      @(negedge clk);
      baud_k = 19'd16;
      rx     = 1'b0;
      start_q.push_back('{cyc: cyc + 1, len: 8});
      busy_q.push_back(cyc + 1 + 8);
      repeat (3) @(negedge clk);
      rx = 1'b1;
      idle(15);
      check("glitch_busy", int'(busy), 0);

      // Mid-frame config change after the 3rd btu; next frame picks up k=32, no parity.
      send_frame(16, 1'b1, 1'b1, 8'h3C, 3, 32, 1'b0, 0);
      idle(4);
      send_frame(32, 1'b1, 1'b0, 8'h81, 0, 0, 1'b0, 0);
      idle(4);

      // Async reset between btu 4 and 5, then idle line, then clamp k=0 -> 2.
      send_frame(16, 1'b1, 1'b1, 8'hF0, 0, 0, 1'b0, 4);
      idle(20);
      reset_check("post_abort");
      send_frame(0, 1'b1, 1'b1, 8'h5A, 0, 0, 1'b0, 0);
      idle(3);
      send_frame(1, 1'b0, 1'b1, 8'h12, 0, 0, 1'b0, 0);
      idle(3);

      // Back-to-back frames: next start bit sampled the cycle after done.
      send_frame(16, 1'b1, 1'b1, 8'h6C, 0, 0, 1'b0, 0);
      send_frame(16, 1'b1, 1'b1, 8'h6C, 0, 0, 1'b0, 0);
      idle(3);

      // Randomized frames with random spacing (gap 0 is back-to-back).
      for (int i = 0; i < 14; i++) begin
         int gap;
         send_frame(int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom), 8'($urandom),
                    0, 0, 1'b0, 0);
         gap = int'($urandom_range(0, 4));
         if (gap > 0) idle(gap);
      end

      idle(60);
      check("btu_q_drained", btu_q.size(), 0);
      check("start_q_drained", start_q.size(), 0);
      check("busy_q_drained", busy_q.size(), 0);
      check("final_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
